// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a debounced lock,
// raises ready for the core reset tree, retries failed lock attempts and
// re-sequences on loss of lock. Clocked only by the free-running refclk.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 50000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int GLITCH_FILTER       = 4,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked_in,
  input  logic          soft_reset_req,
  output logic          pll_rst,
  output logic          ready,
  output logic          lock_lost,
  output logic          fault,
  output logic [RW-1:0] retry_count,
  output logic [2:0]    state_dbg
);

  localparam int RST_W  = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int GL_W   = $clog2(GLITCH_FILTER) + 1;

  // Terminal values: the pulse, timeout and glitch counters fire on the edge
  // that completes their N-th cycle; the stability counter must have reached
  // its limit before RUN is entered.
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GL_W-1:0]   GL_LAST   = GL_W'(GLITCH_FILTER - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t              state_q;
  logic [RST_W-1:0]    rst_cnt_q;
  logic [STAB_W-1:0]   stab_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [GL_W-1:0]     glitch_cnt_q;
  logic [RW-1:0]       retry_q;
  logic                pll_rst_q, ready_q, lock_lost_q, fault_q;
  logic                sync1_q, locked_s_q;

  // Saturating increments so no counter can ever wrap.
  logic [RST_W-1:0]  rst_cnt_inc;
  logic [STAB_W-1:0] stab_cnt_inc;
  logic [TMO_W-1:0]  tmo_cnt_inc;
  logic [GL_W-1:0]   glitch_cnt_inc;

  assign rst_cnt_inc    = (rst_cnt_q    == '1) ? rst_cnt_q    : rst_cnt_q    + RST_W'(1);
  assign stab_cnt_inc   = (stab_cnt_q   == '1) ? stab_cnt_q   : stab_cnt_q   + STAB_W'(1);
  assign tmo_cnt_inc    = (tmo_cnt_q    == '1) ? tmo_cnt_q    : tmo_cnt_q    + TMO_W'(1);
  assign glitch_cnt_inc = (glitch_cnt_q == '1) ? glitch_cnt_q : glitch_cnt_q + GL_W'(1);

  // Two-flop synchronizer: locked_in comes straight from the PLL, async to refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked_in;
      locked_s_q <= sync1_q;
    end
  end

  // Sequencing FSM with all outputs registered alongside the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      rst_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      glitch_cnt_q <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      if (soft_reset_req) begin
        // Overrides every other transition, including a coincident glitch hit.
        state_q      <= S_RESET_PLL;
        rst_cnt_q    <= '0;
        stab_cnt_q   <= '0;
        tmo_cnt_q    <= '0;
        glitch_cnt_q <= '0;
        retry_q      <= '0;
        pll_rst_q    <= 1'b1;
        ready_q      <= 1'b0;
        fault_q      <= 1'b0;
      end else begin
        case (state_q)
          S_RESET_PLL: begin
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            if (rst_cnt_q >= RST_LAST) begin
              state_q   <= S_WAIT_LOCK;
              rst_cnt_q <= '0;
              tmo_cnt_q <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              rst_cnt_q <= rst_cnt_inc;
            end
          end
          S_WAIT_LOCK, S_STABILIZE: begin
            if (tmo_cnt_q >= TMO_LAST) begin
              // Timeout spans both lock-wait states; a flapping lock cannot reset it.
              stab_cnt_q <= '0;
              rst_cnt_q  <= '0;
              pll_rst_q  <= 1'b1;
              if (retry_q < RETRY_MAX) begin
                retry_q <= retry_q + RW'(1);
                state_q <= S_RESET_PLL;
              end else begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
              end
            end else begin
              tmo_cnt_q <= tmo_cnt_inc;
              if (state_q == S_WAIT_LOCK) begin
                if (locked_s_q) begin
                  state_q    <= S_STABILIZE;
                  stab_cnt_q <= '0;
                end
              end else if (!locked_s_q) begin
                state_q <= S_WAIT_LOCK;
              end else if (stab_cnt_q >= STAB_DONE) begin
                state_q      <= S_RUN;
                ready_q      <= 1'b1;
                retry_q      <= '0;
                glitch_cnt_q <= '0;
              end else begin
                stab_cnt_q <= stab_cnt_inc;
              end
            end
          end
          S_RUN: begin
            ready_q <= 1'b1;
            if (locked_s_q) begin
              glitch_cnt_q <= '0;
            end else if (glitch_cnt_q >= GL_LAST) begin
              lock_lost_q  <= 1'b1;
              ready_q      <= 1'b0;
              pll_rst_q    <= 1'b1;
              state_q      <= S_RESET_PLL;
              rst_cnt_q    <= '0;
              glitch_cnt_q <= '0;
            end else begin
              glitch_cnt_q <= glitch_cnt_inc;
            end
          end
          S_FAULT: begin
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b1;
          end
          default: begin
            state_q   <= S_RESET_PLL;
            rst_cnt_q <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst     = pll_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule
